// File: rtl/qdrc_wr.sv
// QDR controller write path: queues user writes and issues them to the PHY.
// Each write goes out as an address strobe, followed later by its data beats and byte enables.
module qdrc_wr #(
    parameter int DATA_WIDTH      = 36,
    parameter int ADDR_WIDTH      = 21,
    parameter int BE_WIDTH        = 2*DATA_WIDTH/9,
    parameter int FIFO_AW         = 4,
    parameter int WR_DATA_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    phy_rdy,
    input  logic                    usr_strb,
    input  logic [ADDR_WIDTH-1:0]   usr_addr,
    input  logic [2*DATA_WIDTH-1:0] usr_data,
    input  logic [BE_WIDTH-1:0]     usr_be,
    output logic                    usr_full,
    output logic                    usr_overflow,
    input  logic                    rd_strb,
    output logic                    phy_strb,
    output logic [ADDR_WIDTH-1:0]   phy_addr,
    output logic [2*DATA_WIDTH-1:0] phy_data,
    output logic [BE_WIDTH-1:0]     phy_be
);
    localparam int DEPTH = 2**FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0]   mem_addr [DEPTH];
    logic [2*DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [BE_WIDTH-1:0]     mem_be   [DEPTH];

    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               push;
    logic               pop;

    logic [2*DATA_WIDTH-1:0] strb_data_p0;
    logic [BE_WIDTH-1:0]     strb_be_p0;

    logic                    vld_pipe  [WR_DATA_LATENCY];
    logic [2*DATA_WIDTH-1:0] data_pipe [WR_DATA_LATENCY];
    logic [BE_WIDTH-1:0]     be_pipe   [WR_DATA_LATENCY];

    assign full     = (count == DEPTH_CNT);
    assign usr_full = full;
    assign push     = usr_strb && !full;
    // Reads own the address slot, so a read strobe blocks issue for that cycle.
    assign pop      = phy_rdy && (count != '0) && !rd_strb;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= usr_addr;
            mem_data[wr_ptr] <= usr_data;
            mem_be[wr_ptr]   <= usr_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            usr_overflow <= 1'b0;
            phy_strb     <= 1'b0;
            phy_addr     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (usr_strb && full) usr_overflow <= 1'b1;
            phy_strb <= pop;
            if (pop) phy_addr <= mem_addr[rd_ptr];
        end
    end

    // Stage p0: payload of the write being strobed this cycle.
    always_ff @(posedge clk) begin
        if (pop) begin
            strb_data_p0 <= mem_data[rd_ptr];
            strb_be_p0   <= mem_be[rd_ptr];
        end
    end

    // Data stages: loaded on the strobe cycle, shifted once per clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < WR_DATA_LATENCY; k++) vld_pipe[k] <= 1'b0;
        end else begin
            vld_pipe[0] <= phy_strb;
            for (int k = 1; k < WR_DATA_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        data_pipe[0] <= strb_data_p0;
        be_pipe[0]   <= strb_be_p0;
        for (int k = 1; k < WR_DATA_LATENCY; k++) begin
            data_pipe[k] <= data_pipe[k-1];
            be_pipe[k]   <= be_pipe[k-1];
        end
    end

    // A zero byte-enable mask tells the PHY no byte is written.
    assign phy_data = vld_pipe[WR_DATA_LATENCY-1] ? data_pipe[WR_DATA_LATENCY-1] : '0;
    assign phy_be   = vld_pipe[WR_DATA_LATENCY-1] ? be_pipe[WR_DATA_LATENCY-1]   : '0;
endmodule

// File: tb/tb_qdrc_wr.sv
// Bench for qdrc_wr: two instances (data latency 1 and 3) share stimulus and are
// checked every cycle against a queue-based model, plus a few literal expectations.
module tb_qdrc_wr;
    localparam int AW = 21;
    localparam int DW = 72;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          reset, phy_rdy, usr_strb, rd_strb;
    logic [AW-1:0] usr_addr;
    logic [DW-1:0] usr_data;
    logic [BW-1:0] usr_be;

    logic          full_a, ovf_a, strb_a, full_b, ovf_b, strb_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic [BW-1:0] be_a, be_b;

    always #5 clk = ~clk;

    qdrc_wr #(.WR_DATA_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .phy_rdy(phy_rdy), .usr_strb(usr_strb),
        .usr_addr(usr_addr), .usr_data(usr_data), .usr_be(usr_be),
        .usr_full(full_a), .usr_overflow(ovf_a), .rd_strb(rd_strb),
        .phy_strb(strb_a), .phy_addr(addr_a), .phy_data(data_a), .phy_be(be_a)
    );

    qdrc_wr #(.WR_DATA_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .phy_rdy(phy_rdy), .usr_strb(usr_strb),
        .usr_addr(usr_addr), .usr_data(usr_data), .usr_be(usr_be),
        .usr_full(full_b), .usr_overflow(ovf_b), .rd_strb(rd_strb),
        .phy_strb(strb_b), .phy_addr(addr_b), .phy_data(data_b), .phy_be(be_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a queue of pending writes and a history of issued strobes.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } entry_t;

    typedef struct packed {
        logic          vld;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } beat_t;

    entry_t        q[$];
    entry_t        head;
    beat_t         hist[5];
    logic [AW-1:0] exp_addr;
    logic          exp_ovf;
    bit            armed = 0;
    bit            full_now, iss;

    always begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            q.delete();
            for (int k = 0; k < 5; k++) hist[k] = '0;
            exp_addr = '0;
            exp_ovf  = 1'b0;
            armed    = 1;
        end else begin
            full_now = (q.size() == 16);
            iss      = phy_rdy && (q.size() != 0) && !rd_strb;
            for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = '0;
            if (iss) begin
                head     = q.pop_front();
                exp_addr = head.addr;
                hist[0]  = '{vld: 1'b1, data: head.data, be: head.be};
            end
            if (usr_strb && full_now) exp_ovf = 1'b1;
            if (usr_strb && !full_now) q.push_back('{addr: usr_addr, data: usr_data, be: usr_be});
        end
        #1;
        if (armed) begin
            chk("m_strb_a", DW'(strb_a), DW'(hist[0].vld));
            chk("m_strb_b", DW'(strb_b), DW'(hist[0].vld));
            chk("m_addr_a", DW'(addr_a), DW'(exp_addr));
            chk("m_addr_b", DW'(addr_b), DW'(exp_addr));
            chk("m_full_a", DW'(full_a), DW'(q.size() == 16));
            chk("m_full_b", DW'(full_b), DW'(q.size() == 16));
            chk("m_ovf_a",  DW'(ovf_a),  DW'(exp_ovf));
            chk("m_ovf_b",  DW'(ovf_b),  DW'(exp_ovf));
            chk("m_data_a", data_a, hist[1].vld ? hist[1].data : '0);
            chk("m_be_a",   DW'(be_a), DW'(hist[1].vld ? hist[1].be : '0));
            chk("m_data_b", data_b, hist[3].vld ? hist[3].data : '0);
            chk("m_be_b",   DW'(be_b), DW'(hist[3].vld ? hist[3].be : '0));
        end
    end

    task automatic push_one(input logic [AW-1:0] a);
        usr_strb = 1'b1;
        usr_addr = a;
        usr_data = {$urandom, $urandom, 8'($urandom)};
        usr_be   = 8'($urandom);
        @(negedge clk);
        usr_strb = 1'b0;
    endtask

    initial begin
        reset = 1'b1; phy_rdy = 1'b0; usr_strb = 1'b0; rd_strb = 1'b0;
        usr_addr = '0; usr_data = '0; usr_be = '0;
        repeat (3) @(negedge clk);
        chk("rst_strb", DW'(strb_a), '0);
        chk("rst_full", DW'(full_a), '0);
        chk("rst_data", data_a, '0);
        reset = 1'b0;

        // Single write: strobe two cycles after the push edge, data one/three later.
        phy_rdy  = 1'b1;
        usr_strb = 1'b1;
        usr_addr = 21'h1A5;
        usr_data = 72'h123456789ABCDEF012;
        usr_be   = 8'hFF;
        @(negedge clk);
        usr_strb = 1'b0;
        chk("t1_strb_early", DW'(strb_a), '0);
        @(negedge clk);
        chk("t1_strb", DW'(strb_a), 72'd1);
        chk("t1_addr", DW'(addr_a), 72'h1A5);
        chk("t1_data_early", data_a, '0);
        @(negedge clk);
        chk("t1_data_a", data_a, 72'h123456789ABCDEF012);
        chk("t1_be_a", DW'(be_a), 72'hFF);
        chk("t1_strb_off", DW'(strb_a), '0);
        @(negedge clk);
        chk("t1_data_a_off", data_a, '0);
        @(negedge clk);
        chk("t1_data_b", data_b, 72'h123456789ABCDEF012);
        chk("t1_be_b", DW'(be_b), 72'hFF);

        // Fill while PHY not ready, overflow on the 17th, then drain.
        phy_rdy = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push_one(AW'(32'h100 + i));
            if (i == 15) begin
                chk("t2_full", DW'(full_a), 72'd1);
                chk("t2_no_ovf", DW'(ovf_a), '0);
            end
        end
        chk("t2_ovf", DW'(ovf_a), 72'd1);
        phy_rdy = 1'b1;
        @(negedge clk);
        chk("t2_full_drop", DW'(full_a), '0);
        chk("t2_first_addr", DW'(addr_a), 72'h100);
        repeat (18) @(negedge clk);

        // Read strobe interrupts a short drain.
        phy_rdy = 1'b0;
        for (int i = 0; i < 3; i++) push_one(AW'(32'h200 + i));
        phy_rdy = 1'b1;
        @(negedge clk);
        rd_strb = 1'b1;
        repeat (2) @(negedge clk);
        rd_strb = 1'b0;
        repeat (6) @(negedge clk);

        // Steady push+pop at count 5 across the pointer wrap.
        phy_rdy = 1'b0;
        for (int i = 0; i < 5; i++) push_one(AW'(32'h300 + i));
        phy_rdy = 1'b1;
        for (int i = 0; i < 20; i++) push_one(AW'(32'h400 + i));
        repeat (8) @(negedge clk);

        // Reset with writes queued and one in the data stages.
        phy_rdy = 1'b0;
        for (int i = 0; i < 5; i++) push_one(AW'(32'h500 + i));
        phy_rdy = 1'b1;
        @(negedge clk);
        phy_rdy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_strb", DW'(strb_a), '0);
        chk("t5_addr", DW'(addr_a), '0);
        chk("t5_data", data_a, '0);
        chk("t5_ovf", DW'(ovf_a), '0);
        chk("t5_data_b", data_b, '0);

        // Randomized traffic with varying push/ready/read pressure.
        for (int i = 0; i < 3000; i++) begin
            phy_rdy  = ((i / 200) % 3 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
            rd_strb  = ($urandom_range(0, 3) == 0);
            usr_strb = ($urandom_range(0, 9) < 6);
            usr_addr = AW'($urandom);
            usr_data = {$urandom, $urandom, 8'($urandom)};
            usr_be   = 8'($urandom);
            reset    = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        reset = 1'b0; usr_strb = 1'b0; rd_strb = 1'b0; phy_rdy = 1'b1;
        repeat (30) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
